// File: rtl/mk_network.sv
// mk_network: 9-port single-hop switch with 4-deep input FIFOs, per-output round-robin
// arbitration, registered outputs and one-cycle credit return.
module mk_network (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [70:0] send_ports_0_putFlit_flit_in,
    input  logic        EN_send_ports_0_putFlit,
    output logic [1:0]  send_ports_0_getCredits,
    input  logic        EN_send_ports_0_getCredits,
    output logic [70:0] recv_ports_0_getFlit,
    input  logic        EN_recv_ports_0_getFlit,
    input  logic [1:0]  recv_ports_0_putCredits_cr_in,
    input  logic        EN_recv_ports_0_putCredits,
    input  logic [70:0] send_ports_1_putFlit_flit_in,
    input  logic        EN_send_ports_1_putFlit,
    output logic [1:0]  send_ports_1_getCredits,
    input  logic        EN_send_ports_1_getCredits,
    output logic [70:0] recv_ports_1_getFlit,
    input  logic        EN_recv_ports_1_getFlit,
    input  logic [1:0]  recv_ports_1_putCredits_cr_in,
    input  logic        EN_recv_ports_1_putCredits,
    input  logic [70:0] send_ports_2_putFlit_flit_in,
    input  logic        EN_send_ports_2_putFlit,
    output logic [1:0]  send_ports_2_getCredits,
    input  logic        EN_send_ports_2_getCredits,
    output logic [70:0] recv_ports_2_getFlit,
    input  logic        EN_recv_ports_2_getFlit,
    input  logic [1:0]  recv_ports_2_putCredits_cr_in,
    input  logic        EN_recv_ports_2_putCredits,
    input  logic [70:0] send_ports_3_putFlit_flit_in,
    input  logic        EN_send_ports_3_putFlit,
    output logic [1:0]  send_ports_3_getCredits,
    input  logic        EN_send_ports_3_getCredits,
    output logic [70:0] recv_ports_3_getFlit,
    input  logic        EN_recv_ports_3_getFlit,
    input  logic [1:0]  recv_ports_3_putCredits_cr_in,
    input  logic        EN_recv_ports_3_putCredits,
    input  logic [70:0] send_ports_4_putFlit_flit_in,
    input  logic        EN_send_ports_4_putFlit,
    output logic [1:0]  send_ports_4_getCredits,
    input  logic        EN_send_ports_4_getCredits,
    output logic [70:0] recv_ports_4_getFlit,
    input  logic        EN_recv_ports_4_getFlit,
    input  logic [1:0]  recv_ports_4_putCredits_cr_in,
    input  logic        EN_recv_ports_4_putCredits,
    input  logic [70:0] send_ports_5_putFlit_flit_in,
    input  logic        EN_send_ports_5_putFlit,
    output logic [1:0]  send_ports_5_getCredits,
    input  logic        EN_send_ports_5_getCredits,
    output logic [70:0] recv_ports_5_getFlit,
    input  logic        EN_recv_ports_5_getFlit,
    input  logic [1:0]  recv_ports_5_putCredits_cr_in,
    input  logic        EN_recv_ports_5_putCredits,
    input  logic [70:0] send_ports_6_putFlit_flit_in,
    input  logic        EN_send_ports_6_putFlit,
    output logic [1:0]  send_ports_6_getCredits,
    input  logic        EN_send_ports_6_getCredits,
    output logic [70:0] recv_ports_6_getFlit,
    input  logic        EN_recv_ports_6_getFlit,
    input  logic [1:0]  recv_ports_6_putCredits_cr_in,
    input  logic        EN_recv_ports_6_putCredits,
    input  logic [70:0] send_ports_7_putFlit_flit_in,
    input  logic        EN_send_ports_7_putFlit,
    output logic [1:0]  send_ports_7_getCredits,
    input  logic        EN_send_ports_7_getCredits,
    output logic [70:0] recv_ports_7_getFlit,
    input  logic        EN_recv_ports_7_getFlit,
    input  logic [1:0]  recv_ports_7_putCredits_cr_in,
    input  logic        EN_recv_ports_7_putCredits,
    input  logic [70:0] send_ports_8_putFlit_flit_in,
    input  logic        EN_send_ports_8_putFlit,
    output logic [1:0]  send_ports_8_getCredits,
    input  logic        EN_send_ports_8_getCredits,
    output logic [70:0] recv_ports_8_getFlit,
    input  logic        EN_recv_ports_8_getFlit,
    input  logic [1:0]  recv_ports_8_putCredits_cr_in,
    input  logic        EN_recv_ports_8_putCredits
);
    localparam int NUM_PORTS = 9;
    localparam int FIFO_DEPTH = 4;
    localparam int CREDITS_PER_VC = 2;

    logic [70:0] put_flit [NUM_PORTS];
    logic [NUM_PORTS-1:0] put_en, get_en;
    logic [70:0] mem [NUM_PORTS][FIFO_DEPTH];
    logic [1:0] rp [NUM_PORTS];
    logic [1:0] wp [NUM_PORTS];
    logic [2:0] cnt [NUM_PORTS];
    logic [70:0] head [NUM_PORTS];
    logic [NUM_PORTS-1:0] hv, bad, deq, enq, has_win;
    logic [3:0] rr [NUM_PORTS];
    logic [3:0] win [NUM_PORTS];
    logic [70:0] out_q [NUM_PORTS];
    logic [1:0] cr_q [NUM_PORTS];
    logic [4:0] sum;
    logic [3:0] idx;
    logic unused_ok;

    assign put_flit[0] = send_ports_0_putFlit_flit_in; assign put_en[0] = EN_send_ports_0_putFlit; assign get_en[0] = EN_recv_ports_0_getFlit; assign send_ports_0_getCredits = cr_q[0]; assign recv_ports_0_getFlit = out_q[0];
    assign put_flit[1] = send_ports_1_putFlit_flit_in; assign put_en[1] = EN_send_ports_1_putFlit; assign get_en[1] = EN_recv_ports_1_getFlit; assign send_ports_1_getCredits = cr_q[1]; assign recv_ports_1_getFlit = out_q[1];
    assign put_flit[2] = send_ports_2_putFlit_flit_in; assign put_en[2] = EN_send_ports_2_putFlit; assign get_en[2] = EN_recv_ports_2_getFlit; assign send_ports_2_getCredits = cr_q[2]; assign recv_ports_2_getFlit = out_q[2];
    assign put_flit[3] = send_ports_3_putFlit_flit_in; assign put_en[3] = EN_send_ports_3_putFlit; assign get_en[3] = EN_recv_ports_3_getFlit; assign send_ports_3_getCredits = cr_q[3]; assign recv_ports_3_getFlit = out_q[3];
    assign put_flit[4] = send_ports_4_putFlit_flit_in; assign put_en[4] = EN_send_ports_4_putFlit; assign get_en[4] = EN_recv_ports_4_getFlit; assign send_ports_4_getCredits = cr_q[4]; assign recv_ports_4_getFlit = out_q[4];
    assign put_flit[5] = send_ports_5_putFlit_flit_in; assign put_en[5] = EN_send_ports_5_putFlit; assign get_en[5] = EN_recv_ports_5_getFlit; assign send_ports_5_getCredits = cr_q[5]; assign recv_ports_5_getFlit = out_q[5];
    assign put_flit[6] = send_ports_6_putFlit_flit_in; assign put_en[6] = EN_send_ports_6_putFlit; assign get_en[6] = EN_recv_ports_6_getFlit; assign send_ports_6_getCredits = cr_q[6]; assign recv_ports_6_getFlit = out_q[6];
    assign put_flit[7] = send_ports_7_putFlit_flit_in; assign put_en[7] = EN_send_ports_7_putFlit; assign get_en[7] = EN_recv_ports_7_getFlit; assign send_ports_7_getCredits = cr_q[7]; assign recv_ports_7_getFlit = out_q[7];
    assign put_flit[8] = send_ports_8_putFlit_flit_in; assign put_en[8] = EN_send_ports_8_putFlit; assign get_en[8] = EN_recv_ports_8_getFlit; assign send_ports_8_getCredits = cr_q[8]; assign recv_ports_8_getFlit = out_q[8];

    // Credit acknowledges and sink-side credit inputs have no effect: sinks are always ready.
    assign unused_ok = ^{EN_send_ports_0_getCredits, EN_send_ports_1_getCredits, EN_send_ports_2_getCredits,
                         EN_send_ports_3_getCredits, EN_send_ports_4_getCredits, EN_send_ports_5_getCredits,
                         EN_send_ports_6_getCredits, EN_send_ports_7_getCredits, EN_send_ports_8_getCredits,
                         recv_ports_0_putCredits_cr_in, recv_ports_1_putCredits_cr_in, recv_ports_2_putCredits_cr_in,
                         recv_ports_3_putCredits_cr_in, recv_ports_4_putCredits_cr_in, recv_ports_5_putCredits_cr_in,
                         recv_ports_6_putCredits_cr_in, recv_ports_7_putCredits_cr_in, recv_ports_8_putCredits_cr_in,
                         EN_recv_ports_0_putCredits, EN_recv_ports_1_putCredits, EN_recv_ports_2_putCredits,
                         EN_recv_ports_3_putCredits, EN_recv_ports_4_putCredits, EN_recv_ports_5_putCredits,
                         EN_recv_ports_6_putCredits, EN_recv_ports_7_putCredits, EN_recv_ports_8_putCredits,
                         2'(CREDITS_PER_VC)};

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            head[k] = mem[k][rp[k]];
            hv[k] = cnt[k] != 3'd0;
            bad[k] = hv[k] && head[k][68:65] >= 4'(NUM_PORTS);
        end
        deq = bad;
        has_win = '0;
        sum = '0;
        idx = '0;
        // Scan requesters starting at rr[j]; first hit wins.
        for (int j = 0; j < NUM_PORTS; j++) begin
            win[j] = '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                sum = {1'b0, rr[j]} + 5'(o);
                idx = sum >= 5'(NUM_PORTS) ? 4'(sum - 5'(NUM_PORTS)) : sum[3:0];
                if (!has_win[j] && hv[idx] && head[idx][68:65] == 4'(j)) begin
                    has_win[j] = 1'b1;
                    win[j] = idx;
                end
            end
            if (has_win[j]) deq[win[j]] = 1'b1;
        end
        for (int k = 0; k < NUM_PORTS; k++)
            enq[k] = put_en[k] && put_flit[k][70] && (cnt[k] != 3'(FIFO_DEPTH) || deq[k]);
    end

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                rp[k] <= '0;
                wp[k] <= '0;
                cnt[k] <= '0;
                rr[k] <= '0;
                out_q[k] <= '0;
                cr_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (enq[k]) begin
                    mem[k][wp[k]] <= put_flit[k];
                    wp[k] <= wp[k] + 2'd1;
                end
                if (deq[k]) rp[k] <= rp[k] + 2'd1;
                cnt[k] <= cnt[k] + 3'(enq[k]) - 3'(deq[k]);
                cr_q[k] <= deq[k] ? {1'b1, head[k][64]} : 2'b00;
                if (has_win[k]) begin
                    out_q[k] <= head[win[k]];
                    rr[k] <= win[k] == 4'(NUM_PORTS - 1) ? 4'd0 : win[k] + 4'd1;
                end else if (get_en[k]) begin
                    out_q[k][70] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mk_network.sv
// tb_mk_network: directed checks of reset, delivery latency, hold/clear, streaming,
// round-robin contention, overload dropping, bad destinations and mid-transfer reset.
module tb_mk_network;
    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    logic [70:0] fin [9];
    logic [70:0] gf [9];
    logic [1:0] cr [9];
    logic [1:0] crin [9];
    logic [8:0] en_put, en_get, en_gc, en_pc;
    logic [70:0] e;
    int n = 0;
    int errs = 0;
    int ncr;

    always #5 CLK = ~CLK;

    mk_network dut (
        .CLK(CLK), .RST_N(RST_N),
        .send_ports_0_putFlit_flit_in(fin[0]), .EN_send_ports_0_putFlit(en_put[0]), .send_ports_0_getCredits(cr[0]), .EN_send_ports_0_getCredits(en_gc[0]), .recv_ports_0_getFlit(gf[0]), .EN_recv_ports_0_getFlit(en_get[0]), .recv_ports_0_putCredits_cr_in(crin[0]), .EN_recv_ports_0_putCredits(en_pc[0]),
        .send_ports_1_putFlit_flit_in(fin[1]), .EN_send_ports_1_putFlit(en_put[1]), .send_ports_1_getCredits(cr[1]), .EN_send_ports_1_getCredits(en_gc[1]), .recv_ports_1_getFlit(gf[1]), .EN_recv_ports_1_getFlit(en_get[1]), .recv_ports_1_putCredits_cr_in(crin[1]), .EN_recv_ports_1_putCredits(en_pc[1]),
        .send_ports_2_putFlit_flit_in(fin[2]), .EN_send_ports_2_putFlit(en_put[2]), .send_ports_2_getCredits(cr[2]), .EN_send_ports_2_getCredits(en_gc[2]), .recv_ports_2_getFlit(gf[2]), .EN_recv_ports_2_getFlit(en_get[2]), .recv_ports_2_putCredits_cr_in(crin[2]), .EN_recv_ports_2_putCredits(en_pc[2]),
        .send_ports_3_putFlit_flit_in(fin[3]), .EN_send_ports_3_putFlit(en_put[3]), .send_ports_3_getCredits(cr[3]), .EN_send_ports_3_getCredits(en_gc[3]), .recv_ports_3_getFlit(gf[3]), .EN_recv_ports_3_getFlit(en_get[3]), .recv_ports_3_putCredits_cr_in(crin[3]), .EN_recv_ports_3_putCredits(en_pc[3]),
        .send_ports_4_putFlit_flit_in(fin[4]), .EN_send_ports_4_putFlit(en_put[4]), .send_ports_4_getCredits(cr[4]), .EN_send_ports_4_getCredits(en_gc[4]), .recv_ports_4_getFlit(gf[4]), .EN_recv_ports_4_getFlit(en_get[4]), .recv_ports_4_putCredits_cr_in(crin[4]), .EN_recv_ports_4_putCredits(en_pc[4]),
        .send_ports_5_putFlit_flit_in(fin[5]), .EN_send_ports_5_putFlit(en_put[5]), .send_ports_5_getCredits(cr[5]), .EN_send_ports_5_getCredits(en_gc[5]), .recv_ports_5_getFlit(gf[5]), .EN_recv_ports_5_getFlit(en_get[5]), .recv_ports_5_putCredits_cr_in(crin[5]), .EN_recv_ports_5_putCredits(en_pc[5]),
        .send_ports_6_putFlit_flit_in(fin[6]), .EN_send_ports_6_putFlit(en_put[6]), .send_ports_6_getCredits(cr[6]), .EN_send_ports_6_getCredits(en_gc[6]), .recv_ports_6_getFlit(gf[6]), .EN_recv_ports_6_getFlit(en_get[6]), .recv_ports_6_putCredits_cr_in(crin[6]), .EN_recv_ports_6_putCredits(en_pc[6]),
        .send_ports_7_putFlit_flit_in(fin[7]), .EN_send_ports_7_putFlit(en_put[7]), .send_ports_7_getCredits(cr[7]), .EN_send_ports_7_getCredits(en_gc[7]), .recv_ports_7_getFlit(gf[7]), .EN_recv_ports_7_getFlit(en_get[7]), .recv_ports_7_putCredits_cr_in(crin[7]), .EN_recv_ports_7_putCredits(en_pc[7]),
        .send_ports_8_putFlit_flit_in(fin[8]), .EN_send_ports_8_putFlit(en_put[8]), .send_ports_8_getCredits(cr[8]), .EN_send_ports_8_getCredits(en_gc[8]), .recv_ports_8_getFlit(gf[8]), .EN_recv_ports_8_getFlit(en_get[8]), .recv_ports_8_putCredits_cr_in(crin[8]), .EN_recv_ports_8_putCredits(en_pc[8])
    );

    function automatic logic [70:0] mk(input logic t, input logic [3:0] d, input logic v, input logic [63:0] x);
        return {1'b1, t, d, v, x};
    endfunction

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle;
        en_put = '0; en_get = '0; en_gc = '0; en_pc = '0;
        for (int k = 0; k < 9; k++) begin
            fin[k] = '0;
            crin[k] = '0;
        end
    endtask

    initial begin
        idle();
        // Reset held with random inputs
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 9; k++) begin
                fin[k] = {7'($urandom), $urandom, $urandom};
                crin[k] = 2'($urandom);
            end
            en_put = 9'($urandom); en_get = 9'($urandom); en_gc = 9'($urandom); en_pc = 9'($urandom);
            step();
            for (int k = 0; k < 9; k++) begin
                chk("reset_flit", gf[k], '0);
                chk("reset_cred", 71'(cr[k]), '0);
            end
        end
        idle();
        RST_N = 1'b0;
        step();

        // Self-delivery on port 2, then hold and clear
        fin[2] = mk(1'b1, 4'd2, 1'b1, 64'd13); en_put[2] = 1'b1;
        step();
        en_put[2] = 1'b0;
        step();
        chk("self_flit", gf[2], mk(1'b1, 4'd2, 1'b1, 64'd13));
        chk("self_cred", 71'(cr[2]), 71'd3);
        chk("self_other_out", gf[3], '0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("hold_flit", gf[2], mk(1'b1, 4'd2, 1'b1, 64'd13));
        end
        chk("cred_one_shot", 71'(cr[2]), '0);
        en_get[2] = 1'b1;
        step();
        en_get[2] = 1'b0;
        e = mk(1'b1, 4'd2, 1'b1, 64'd13);
        e[70] = 1'b0;
        chk("clear_flit", gf[2], e);
        step();
        chk("clear_stays", gf[2], e);

        // Streaming on port 5 for 20 cycles
        fin[5] = mk(1'b1, 4'd5, 1'b1, 64'd40); en_put[5] = 1'b1; en_get[5] = 1'b1;
        ncr = 0;
        for (int c = 0; c < 22; c++) begin
            step();
            if (c == 19) en_put[5] = 1'b0;
            if (cr[5][1]) ncr++;
            if (c >= 1 && c <= 20) chk("stream_flit", gf[5], mk(1'b1, 4'd5, 1'b1, 64'd40));
            else chk("stream_idle_valid", 71'(gf[5][70]), '0);
        end
        chk("stream_credits", 71'(ncr), 71'd20);
        en_get[5] = 1'b0;

        // Contention on dest 4, then rotation
        fin[0] = mk(1'b0, 4'd4, 1'b0, 64'd100); fin[1] = mk(1'b1, 4'd4, 1'b1, 64'd101);
        en_put[0] = 1'b1; en_put[1] = 1'b1;
        step();
        en_put = '0;
        step();
        chk("tie1_first", gf[4], mk(1'b0, 4'd4, 1'b0, 64'd100));
        chk("tie1_cred0", 71'(cr[0]), 71'd2);
        step();
        chk("tie1_second", gf[4], mk(1'b1, 4'd4, 1'b1, 64'd101));
        chk("tie1_cred1", 71'(cr[1]), 71'd3);
        fin[0] = mk(1'b0, 4'd4, 1'b0, 64'd102); en_put[0] = 1'b1;
        step();
        en_put = '0;
        step();
        chk("solo_p0", gf[4], mk(1'b0, 4'd4, 1'b0, 64'd102));
        fin[0] = mk(1'b0, 4'd4, 1'b0, 64'd103); fin[1] = mk(1'b1, 4'd4, 1'b1, 64'd104);
        en_put[0] = 1'b1; en_put[1] = 1'b1;
        step();
        en_put = '0;
        step();
        chk("tie2_p1_first", gf[4], mk(1'b1, 4'd4, 1'b1, 64'd104));
        step();
        chk("tie2_p0_second", gf[4], mk(1'b0, 4'd4, 1'b0, 64'd103));

        // Bad destination: dropped with credit, nothing delivered
        en_get = 9'h1FF;
        step();
        en_get = '0;
        fin[3] = mk(1'b1, 4'd12, 1'b1, 64'd77); en_put[3] = 1'b1;
        step();
        en_put = '0;
        step();
        chk("bad_cred", 71'(cr[3]), 71'd3);
        for (int k = 0; k < 9; k++) chk("bad_no_out", 71'(gf[k][70]), '0);
        step();
        for (int k = 0; k < 9; k++) chk("bad_no_out_late", 71'(gf[k][70]), '0);

        // Overload: all ports to dest 0 for 10 cycles; 5 flits per port survive
        for (int k = 0; k < 9; k++) fin[k] = mk(1'b0, 4'd0, k[0], 64'(200 + k));
        en_put = 9'h1FF; en_get[0] = 1'b1;
        ncr = 0;
        for (int c = 0; c < 48; c++) begin
            int p;
            step();
            if (c == 9) en_put = '0;
            for (int k = 0; k < 9; k++) if (cr[k][1]) ncr++;
            p = (c + 8) % 9;
            if (c >= 1 && c <= 45) chk("overload_flit", gf[0], mk(1'b0, 4'd0, p[0], 64'(200 + p)));
            else chk("overload_idle_valid", 71'(gf[0][70]), '0);
        end
        chk("overload_credits", 71'(ncr), 71'd45);
        idle();

        // Reset mid-transfer discards the in-flight flit
        fin[6] = mk(1'b1, 4'd6, 1'b0, 64'd55); en_put[6] = 1'b1;
        step();
        en_put = '0;
        RST_N = 1'b1;
        step();
        RST_N = 1'b0;
        step();
        chk("rst_mid_flit", gf[6], '0);
        chk("rst_mid_cred", 71'(cr[6]), '0);
        step();
        chk("rst_mid_flit_late", gf[6], '0);
        fin[6] = mk(1'b1, 4'd6, 1'b0, 64'd56); en_put[6] = 1'b1;
        step();
        en_put = '0;
        chk("post_rst_not_early", gf[6], '0);
        step();
        chk("post_rst_flit", gf[6], mk(1'b1, 4'd6, 1'b0, 64'd56));
        chk("post_rst_cred", 71'(cr[6]), 71'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule

// File: doc/mk_network.md
MK_NETWORK -- requirements
Module: mk_network

Interface
REQ-001 SHALL have fixed parameters: NUM_PORTS 9, number of endpoints; FIFO_DEPTH 4, flits per input FIFO; CREDITS_PER_VC 2, credits advertised per VC.
REQ-002 SHALL have CLK  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have RST_N  in  1  synchronous, active-high reset (asserted when 1, despite the name).
REQ-004 SHALL have, for k=0..8, send_ports_k_putFlit_flit_in  in  71  injected flit.
REQ-005 SHALL have EN_send_ports_k_putFlit  in  1  inject enable.
REQ-006 SHALL have send_ports_k_getCredits  out  2  credit return {valid, vc}.
REQ-007 SHALL have EN_send_ports_k_getCredits  in  1  credit acknowledge; ignored.
REQ-008 SHALL have recv_ports_k_getFlit  out  71  delivered flit register.
REQ-009 SHALL have EN_recv_ports_k_getFlit  in  1  consume enable.
REQ-010 SHALL have recv_ports_k_putCredits_cr_in  in  2, and EN_recv_ports_k_putCredits  in  1; both are ignored (sinks always ready).

Function
REQ-011 Flit format SHALL be [70] valid, [69] is_tail, [68:65] dest, [64] vc, [63:0] data; tail and vc are carried unmodified.
REQ-012 An input flit SHALL be enqueued into input FIFO k at a rising edge when EN_putFlit=1, flit[70]=1, and the FIFO is not full.
  - Otherwise no enqueue.
  - A flit offered while the FIFO is full SHALL be dropped silently.
  - A simultaneous dequeue frees a slot in the same cycle, so enqueue-when-full-with-dequeue succeeds.
REQ-013 Each output j SHALL arbitrate combinationally among the FIFO heads whose dest==j.
  - Arbitration SHALL be round-robin, starting from pointer rr_j.
  - The winner is dequeued and rr_j becomes winner+1 (mod 9).
  - rr_j SHALL be unchanged when there are no requests.
REQ-014 A head flit with dest >= 9 SHALL be dequeued and discarded in the cycle it reaches the head, with a credit returned.
REQ-015 Latency SHALL be exactly 2 cycles with no contention: a flit presented in cycle t appears on recv_ports_dest_getFlit from cycle t+2.
REQ-016 Throughput SHALL be one flit per output per cycle; disjoint destinations SHALL never block each other.
REQ-017 Output register j SHALL update as follows:
  - Loaded with the winning flit (valid=1) when there is a winner.
  - Otherwise, if EN_recv_getFlit=1, only bit 70 is cleared and bits [69:0] are held.
  - Otherwise the whole register is held.
REQ-018 send_ports_k_getCredits SHALL be a register.
  - Set to {1, vc of the dequeued flit} in the cycle after input FIFO k dequeues.
  - Otherwise set to 2'b00.
REQ-019 Senders SHALL be allowed at most 2 outstanding flits per VC per port; the FIFO depth of 4 guarantees these never drop.
REQ-020 Each FIFO SHALL be a circular buffer with wrap-around pointers and an occupancy counter of 0..4; it SHALL never overflow or underflow.

Reset
REQ-021 While RST_N=1 at a rising edge, the block SHALL reset as follows:
  - All FIFOs empty and all rr pointers 0.
  - All recv_ports_k_getFlit = 71'b0 and all send_ports_k_getCredits = 2'b00.
  - All inputs ignored.
REQ-022 Reset asserted mid-transfer SHALL discard all in-flight flits; the first post-reset injection behaves per REQ-015.

Verification
REQ-023 Reset: hold RST_N=1 for 5 cycles with random inputs -> all getFlit=0 and getCredits=0 throughout.
REQ-024 Self-delivery: port 2 sends {1,1,4'd2,1,64'd13} for one cycle at t -> recv_ports_2_getFlit[63:0]=13 with valid=1 at t+2; send_ports_2_getCredits=2'b11 at t+2.
REQ-025 Hold and clear: after REQ-024 with EN_recv_ports_2_getFlit=0 -> data 13 with valid=1 held indefinitely; with EN=1 instead -> valid=0 at t+3 and data 13 retained.
REQ-026 Streaming: port 5 sends {1,1,4'd5,1,64'd40} every cycle for 20 cycles -> recv 5 valid with data 40 every cycle t+2..t+21, and 20 credits returned.
REQ-027 Contention: ports 0 and 1 send to dest 4 in the same cycle with rr=0 -> port 0's flit at t+2, port 1's at t+3; a repeat tie later grants port 1 first.
REQ-028 Overload and bad destination:
  - All 9 ports send to dest 0 every cycle for 10 cycles -> output 0 delivers one flit per cycle in rotating order, no FIFO exceeds 4, and excess is dropped.
  - A flit with dest 12 -> no output anywhere, and a credit is returned.
